// File: rtl/key_debouncer_mc.sv
// Multi-channel key debouncer with registered press/release strobes.
// Optional two-flop input synchroniser enabled by defining KEY_DEBOUNCER_SYNC_EN.
module key_debouncer_mc #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int GLITCH_TIME_NS = 100,
  parameter int KEY_ACTIVE_LOW = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o,
  output logic                any_event_o
);

  localparam int GLITCH_RAW = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int GLITCH_CYC = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
  localparam int CW         = $clog2(GLITCH_CYC + 1);
  localparam logic [CW-1:0]       LAST = CW'(GLITCH_CYC - 1);
  localparam logic [CHANNELS-1:0] POL  = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CHANNELS-1:0] key_sync;
  logic [CHANNELS-1:0] sample;
  logic [CHANNELS-1:0] state_d;
  logic [CHANNELS-1:0] press_d;
  logic [CHANNELS-1:0] rel_d;
  logic [CW-1:0]       cnt_q [CHANNELS];
  logic [CW-1:0]       cnt_d [CHANNELS];

`ifdef KEY_DEBOUNCER_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign key_sync = sync2_q;
`else
  assign key_sync = key_i;
`endif

  assign sample = key_sync ^ POL;

  // A disagreeing sample bumps the count; GLITCH_CYC consecutive ones flip the level.
  always_comb begin
    state_d = key_state_o;
    press_d = '0;
    rel_d   = '0;
    cnt_d   = '{default: '0};
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      if (sample[n] != key_state_o[n]) begin
        if (cnt_q[n] == LAST) begin
          state_d[n] = sample[n];
          press_d[n] = sample[n];
          rel_d[n]   = ~sample[n];
        end else begin
          cnt_d[n] = cnt_q[n] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_state_o        <= '0;
      key_pressed_stb_o  <= '0;
      key_released_stb_o <= '0;
      cnt_q              <= '{default: '0};
    end else begin
      key_state_o        <= state_d;
      key_pressed_stb_o  <= press_d;
      key_released_stb_o <= rel_d;
      cnt_q              <= cnt_d;
    end
  end

  assign any_event_o = |{key_pressed_stb_o, key_released_stb_o};

endmodule

// File: tb/tb_key_debouncer_mc.sv
// Bench for key_debouncer_mc: directed scenarios plus random bouncing against a run-length model.
module tb_key_debouncer_mc;

  localparam int C   = 4;
  localparam int MHZ = 100;
  localparam int GNS = 100;
`ifdef KEY_DEBOUNCER_SYNC_EN
  localparam int KAL = 1;
  localparam int LAT = 2;
`else
  localparam int KAL = 0;
  localparam int LAT = 0;
`endif
  localparam int GR = GNS * MHZ / 1000;
  localparam int G  = (GR < 1) ? 1 : GR;
  localparam logic [C-1:0] POL = (KAL != 0) ? '1 : '0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [C-1:0] key;
  logic [C-1:0] state_o, press_o, rel_o;
  logic         any_o;

  int checks = 0;
  int errors = 0;

  key_debouncer_mc #(
    .CHANNELS(C),
    .CLK_FREQ_MHZ(MHZ),
    .GLITCH_TIME_NS(GNS),
    .KEY_ACTIVE_LOW(KAL)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .key_i(key),
    .key_state_o(state_o),
    .key_pressed_stb_o(press_o),
    .key_released_stb_o(rel_o),
    .any_event_o(any_o)
  );

  always #5 clk = ~clk;

  // Reference: level flips after G consecutive sampled disagreements with the accepted level.
  logic [C-1:0] exp_state, exp_press, exp_rel;
  logic [C-1:0] m_d1, m_d2;
  int           run [C];

  always @(posedge clk or negedge rst_n) begin
    logic [C-1:0] raw;
    logic         s;
    if (!rst_n) begin
      exp_state = '0; exp_press = '0; exp_rel = '0;
      m_d1 = '0; m_d2 = '0;
      for (int i = 0; i < C; i++) run[i] = 0;
    end else begin
`ifdef KEY_DEBOUNCER_SYNC_EN
      raw  = m_d2;
      m_d2 = m_d1;
      m_d1 = key;
`else
      raw = key;
`endif
      exp_press = '0;
      exp_rel   = '0;
      for (int i = 0; i < C; i++) begin
        s = raw[i] ^ POL[i];
        if (s != exp_state[i]) begin
          run[i]++;
          if (run[i] == G) begin
            exp_state[i] = s;
            if (s) exp_press[i] = 1'b1;
            else   exp_rel[i]   = 1'b1;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_state", 32'(state_o), 32'(exp_state));
    chk("model_press", 32'(press_o), 32'(exp_press));
    chk("model_rel",   32'(rel_o),   32'(exp_rel));
    chk("model_any",   32'(any_o),   32'(|{exp_press, exp_rel}));
  end

  task automatic set_keys(input logic [C-1:0] pressed);
    key = pressed ^ POL;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_keys('0);
    wait_n(3);
    chk("reset_state", 32'(state_o), 32'h0);
    chk("reset_any",   32'(any_o),   32'h0);
    rst_n = 1'b1;
    wait_n(3 + LAT);

    // Single press on channel 0
    set_keys(4'b0001);
    wait_n(G - 1 + LAT);
    chk("press0_early", 32'(state_o), 32'h0);
    wait_n(1);
    chk("press0_stb",   32'(press_o), 32'h1);
    chk("press0_state", 32'(state_o), 32'h1);
    chk("press0_any",   32'(any_o),   32'h1);
    wait_n(1);
    chk("press0_stb_end", 32'(press_o), 32'h0);

    // Channel 1 bounces: 9 high, 1 low, 9 high never qualifies
    for (int i = 0; i < 19; i++) begin
      set_keys((i == 9) ? 4'b0001 : 4'b0011);
      wait_n(1);
      chk("bounce1_stb", 32'(press_o[1]), 32'h0);
    end
    set_keys(4'b0001);
    wait_n(G + LAT);
    chk("bounce1_state", 32'(state_o[1]), 32'h0);

    // Press then release channel 2
    set_keys(4'b0101);
    wait_n(G + LAT);
    chk("press2_stb", 32'(press_o), 32'h4);
    set_keys(4'b0001);
    wait_n(G - 1 + LAT);
    chk("rel2_early", 32'(state_o[2]), 32'h1);
    wait_n(1);
    chk("rel2_stb",   32'(rel_o),      32'h4);
    chk("rel2_any",   32'(any_o),      32'h1);
    chk("rel2_state", 32'(state_o[2]), 32'h0);
    wait_n(1);
    chk("rel2_any_end", 32'(any_o), 32'h0);

    // All channels released, then all pressed together
    set_keys('0);
    wait_n(G + LAT + 2);
    set_keys(4'b1111);
    wait_n(G + LAT);
    chk("all_press", 32'(press_o), 32'hF);
    chk("all_any",   32'(any_o),   32'h1);
    wait_n(1);
    chk("all_any_end", 32'(any_o),   32'h0);
    chk("all_state",   32'(state_o), 32'hF);

    // Reset in the middle of a channel 3 debounce
    set_keys(4'b0001);
    wait_n(G + LAT + 2);
    chk("pre_rst_state", 32'(state_o), 32'h1);
    set_keys(4'b1001);
    wait_n(5 + LAT);
    rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_o), 32'h0);
    chk("rst_press", 32'(press_o), 32'h0);
    chk("rst_any",   32'(any_o),   32'h0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(G - 1 + LAT);
    chk("post_rst_early", 32'(state_o), 32'h0);
    wait_n(1);
    chk("post_rst_press", 32'(press_o), 32'h9);

    // Random bouncing on every channel
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [C-1:0] k;
      k = key;
      for (int i = 0; i < C; i++)
        if ($urandom_range(0, 7) == 0) k[i] = ~k[i];
      key = k;
      if (cyc == 1500) begin
        rst_n = 1'b0;
        wait_n(1);
        rst_n = 1'b1;
      end
      wait_n(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
